seq_detect_fsm: RTL and testbench



---
 rtl/seq_detect_fsm.sv | 112 +++++++++++
 tb/tb_seq_detect_fsm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_fsm.sv
// rtl/seq_detect_fsm.sv - parametrised serial pattern detector with optional match counter
//
// Purpose: consumes one bit per valid cycle, tracks how many leading PATTERN
// bits are matched and pulses match for each complete occurrence. OVERLAP
// selects resuming from the longest proper border (1) or from empty (0).
// Optional feature macro: SEQ_MATCH_CNT_EN adds a saturating match_cnt output.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   clear     - synchronous clear of state/match/history (priority over in_valid)
//   in_valid  - in_bit is consumed on a rising edge while high
//   in_bit    - serial data bit
//   state     - number of pattern-prefix bits currently matched (0..LEN-1)
//   match     - registered one-cycle pulse per completed pattern
//   match_cnt - saturating match count (SEQ_MATCH_CNT_EN only)

module seq_detect_fsm #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8,
    localparam int            SW      = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic [SW-1:0]     state,
    output logic              match
`ifdef SEQ_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]  match_cnt
`endif
);

    // Longest proper prefix of p that is also a suffix of p.
    function automatic int calc_border(input logic [LEN-1:0] p);
        int             b;
        logic [LEN-1:0] mask;
        b = 0;
        for (int l = 1; l < LEN; l++) begin
            mask = {LEN{1'b1}} >> (LEN - l);
            if ((p >> (LEN - l)) == (p & mask)) begin
                b = l;
            end
        end
        return b;
    endfunction

    localparam int BORDER = calc_border(PATTERN);

    // Only the older LEN-1 bits are stored; the newest bit is in_bit itself.
    logic [LEN-2:0] hist;
    logic [LEN-1:0] hist_next;
    int             k_next;
    logic           full;

    // k_next: longest prefix of PATTERN ending at the new bit, bounded by
    // state+1 so history older than the current partial match is ignored.
    always_comb begin
        logic [LEN-1:0] mask;
        hist_next = {hist, in_bit};
        k_next    = 0;
        mask      = '0;
        for (int k = 1; k <= LEN; k++) begin
            mask = {LEN{1'b1}} >> (LEN - k);
            if ((k <= int'(state) + 1) && ((hist_next & mask) == (PATTERN >> (LEN - k)))) begin
                k_next = k;
            end
        end
        full = (k_next == LEN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= '0;
            match <= 1'b0;
            hist  <= '0;
`ifdef SEQ_MATCH_CNT_EN
            match_cnt <= '0;
`endif
        end else if (clear) begin
            state <= '0;
            match <= 1'b0;
            hist  <= '0;
        end else if (in_valid) begin
            hist <= hist_next[LEN-2:0];
            if (full) begin
                match <= 1'b1;
                state <= OVERLAP ? SW'(BORDER) : '0;
`ifdef SEQ_MATCH_CNT_EN
                if (match_cnt != {CNT_W{1'b1}}) begin
                    match_cnt <= match_cnt + 1'b1;
                end
`endif
            end else begin
                match <= 1'b0;
                state <= SW'(k_next);
            end
        end else begin
            match <= 1'b0;
        end
    end

`ifndef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb/tb_seq_detect_fsm.sv - scoreboard bench for seq_detect_fsm (overlap and non-overlap instances)

module tb_seq_detect_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_bit;
    logic [2:0] state_o, state_n;
    logic       match_o, match_n;
`ifdef SEQ_MATCH_CNT_EN
    logic [1:0] cnt_o, cnt_n;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] st_o;
        logic       m_o;
        logic [2:0] st_n;
        logic       m_n;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];

    always #5 clk = ~clk;

    seq_detect_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_ov (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .state(state_o), .match(match_o)
`ifdef SEQ_MATCH_CNT_EN
        , .match_cnt(cnt_o)
`endif
    );

    seq_detect_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) dut_no (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .state(state_n), .match(match_n)
`ifdef SEQ_MATCH_CNT_EN
        , .match_cnt(cnt_n)
`endif
    );

    // Drive one cycle, push the expected outputs, capture observed after the edge.
    task automatic step(input logic v, input logic b, input logic c,
                        input logic [2:0] eso, input logic emo,
                        input logic [2:0] esn, input logic emn);
        obs_t e, o;
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        clear    = c;
        e.st_o = eso; e.m_o = emo; e.st_n = esn; e.m_n = emn;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.st_o = state_o; o.m_o = match_o; o.st_n = state_n; o.m_n = match_n;
        obs_q.push_back(o);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state_o !== 3'd0 || state_n !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d/%0d expected 0/0", state_o, state_n);
        end
        checks++;
        if (match_o !== 1'b0 || match_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_match: got %b/%b expected 0/0", match_o, match_n);
        end
`ifdef SEQ_MATCH_CNT_EN
        checks++;
        if (cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", cnt_o);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [2:0] so[7] = '{1, 2, 3, 1, 2, 3, 1};
        logic [2:0] sn[7] = '{1, 2, 3, 0, 0, 1, 1};
        logic       mo[7] = '{0, 0, 0, 1, 0, 0, 1};
        logic       mn[7] = '{0, 0, 0, 1, 0, 0, 0};
        obs_t e, o;
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i], 1'b0, so[i], mo[i], sn[i], mn[i]);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.st_o !== e.st_o) begin errors++; $display("FAIL overlap[%0d] state_ov: got %0d expected %0d", i, o.st_o, e.st_o); end
            checks++;
            if (o.m_o !== e.m_o) begin errors++; $display("FAIL overlap[%0d] match_ov: got %b expected %b", i, o.m_o, e.m_o); end
            checks++;
            if (o.st_n !== e.st_n) begin errors++; $display("FAIL overlap[%0d] state_nov: got %0d expected %0d", i, o.st_n, e.st_n); end
            checks++;
            if (o.m_n !== e.m_n) begin errors++; $display("FAIL overlap[%0d] match_nov: got %b expected %b", i, o.m_n, e.m_n); end
        end
    endtask

    task automatic test_mismatch();
        logic [5:0] bits = 6'b101011;
        logic [2:0] so[6] = '{1, 2, 3, 2, 3, 1};
        logic [2:0] sn[6] = '{1, 2, 3, 2, 3, 0};
        logic       m[6]  = '{0, 0, 0, 0, 0, 1};
        obs_t e, o;
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, bits[5-i], 1'b0, so[i], m[i], sn[i], m[i]);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.st_o !== e.st_o) begin errors++; $display("FAIL mismatch[%0d] state_ov: got %0d expected %0d", i, o.st_o, e.st_o); end
            checks++;
            if (o.m_o !== e.m_o) begin errors++; $display("FAIL mismatch[%0d] match_ov: got %b expected %b", i, o.m_o, e.m_o); end
            checks++;
            if (o.st_n !== e.st_n) begin errors++; $display("FAIL mismatch[%0d] state_nov: got %0d expected %0d", i, o.st_n, e.st_n); end
            checks++;
            if (o.m_n !== e.m_n) begin errors++; $display("FAIL mismatch[%0d] match_nov: got %b expected %b", i, o.m_n, e.m_n); end
        end
    endtask

    task automatic test_gaps_clear();
        logic [2:0] bits = 3'b101;
        obs_t e, o;
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, bits[2-i], 1'b0, 3'(i + 1), 1'b0, 3'(i + 1), 1'b0);
            if (i < 2) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, ~bits[2-i], 1'b0, 3'(i + 1), 1'b0, 3'(i + 1), 1'b0);
                end
            end
        end
        // clear wins over a valid '1' on the same edge
        step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 3'd1, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.st_o !== e.st_o) begin errors++; $display("FAIL gaps[%0d] state_ov: got %0d expected %0d", i, o.st_o, e.st_o); end
            checks++;
            if (o.m_o !== e.m_o) begin errors++; $display("FAIL gaps[%0d] match_ov: got %b expected %b", i, o.m_o, e.m_o); end
            checks++;
            if (o.st_n !== e.st_n) begin errors++; $display("FAIL gaps[%0d] state_nov: got %0d expected %0d", i, o.st_n, e.st_n); end
            checks++;
            if (o.m_n !== e.m_n) begin errors++; $display("FAIL gaps[%0d] match_nov: got %b expected %b", i, o.m_n, e.m_n); end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] bits = 4'b1011;
        obs_t e, o;
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 3'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 3'd2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 3'd3, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (state_o !== 3'd0 || state_n !== 3'd0) begin
            errors++;
            $display("FAIL async_reset_state: got %0d/%0d expected 0/0", state_o, state_n);
        end
        checks++;
        if (match_o !== 1'b0 || match_n !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_match: got %b/%b expected 0/0", match_o, match_n);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i], 1'b0,
                 (i == 3) ? 3'd1 : 3'(i + 1), (i == 3),
                 (i == 3) ? 3'd0 : 3'(i + 1), (i == 3));
        end
        step(1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.st_o !== e.st_o) begin errors++; $display("FAIL async[%0d] state_ov: got %0d expected %0d", i, o.st_o, e.st_o); end
            checks++;
            if (o.m_o !== e.m_o) begin errors++; $display("FAIL async[%0d] match_ov: got %b expected %b", i, o.m_o, e.m_o); end
            checks++;
            if (o.st_n !== e.st_n) begin errors++; $display("FAIL async[%0d] state_nov: got %0d expected %0d", i, o.st_n, e.st_n); end
            checks++;
            if (o.m_n !== e.m_n) begin errors++; $display("FAIL async[%0d] match_nov: got %b expected %b", i, o.m_n, e.m_n); end
        end
    endtask

`ifdef SEQ_MATCH_CNT_EN
    task automatic test_counter();
        logic [3:0] bits = 4'b1011;
        logic [1:0] exp_cnt[5] = '{1, 2, 3, 3, 3};
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b1, bits[3-i], 1'b0,
                     (i == 3) ? 3'd1 : 3'(i + 1), (i == 3),
                     (i == 3) ? 3'd0 : 3'(i + 1), (i == 3));
            end
            checks++;
            if (cnt_o !== exp_cnt[p] || cnt_n !== exp_cnt[p]) begin
                errors++;
                $display("FAIL cnt[%0d]: got %0d/%0d expected %0d", p, cnt_o, cnt_n, exp_cnt[p]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (cnt_o !== 2'd3) begin
            errors++;
            $display("FAIL cnt_after_clear: got %0d expected 3", cnt_o);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL cnt_after_rst: got %0d expected 0", cnt_o);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_overlap();
        test_mismatch();
        test_gaps_clear();
        test_async_reset();
`ifdef SEQ_MATCH_CNT_EN
        test_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
